// File: rtl/mem_arbiter.sv
// Two-master arbiter (IFU read-only, LSU read/write) in front of a single memory port.
// One transaction in flight, round-robin on contention, hung memory turned into an error response.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int WMASK_W = 8,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               ifu_req_valid,
    output logic               ifu_req_ready,
    input  logic [ADDR_W-1:0]  ifu_addr,
    output logic               ifu_resp_valid,
    input  logic               ifu_resp_ready,
    output logic [DATA_W-1:0]  ifu_rdata,
    output logic               ifu_resp_err,

    input  logic               lsu_req_valid,
    output logic               lsu_req_ready,
    input  logic [ADDR_W-1:0]  lsu_addr,
    input  logic               lsu_wen,
    input  logic [DATA_W-1:0]  lsu_wdata,
    input  logic [WMASK_W-1:0] lsu_wmask,
    output logic               lsu_resp_valid,
    input  logic               lsu_resp_ready,
    output logic [DATA_W-1:0]  lsu_rdata,
    output logic               lsu_resp_err,

    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_wen,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [WMASK_W-1:0] mem_wmask,
    input  logic               mem_resp_valid,
    output logic               mem_resp_ready,
    input  logic [DATA_W-1:0]  mem_rdata
);

    // state | meaning
    // IDLE  | no transaction; grant a requester, drain stale responses
    // ISSUE | mem_req_valid high until memory accepts
    // WAIT  | forward memory response to owner; timeout counter runs
    // ERR   | memory hung; owner gets an error response
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;
    typedef enum logic {OWN_IFU, OWN_LSU} who_t;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    who_t             owner;
    who_t             last;
    logic [CNT_W-1:0] cnt;

    logic grant_ifu;
    logic grant_lsu;
    logic own_ifu;
    logic own_lsu;
    logic in_wait;
    logic in_err;
    logic owner_resp_ready;
    logic [DATA_W-1:0] fwd_rdata;

    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state == IDLE) begin
            if (ifu_req_valid && lsu_req_valid) begin
                grant_ifu = (last == OWN_LSU);
                grant_lsu = (last == OWN_IFU);
            end else begin
                grant_ifu = ifu_req_valid;
                grant_lsu = lsu_req_valid;
            end
        end
    end

    assign own_ifu          = (owner == OWN_IFU);
    assign own_lsu          = (owner == OWN_LSU);
    assign in_wait          = (state == WAIT);
    assign in_err           = (state == ERR);
    assign owner_resp_ready = own_ifu ? ifu_resp_ready : lsu_resp_ready;
    // Writes return no data even if the memory drives something on rdata.
    assign fwd_rdata        = mem_wen ? '0 : mem_rdata;

    // Everything handshake-related is gated by rst so the block is silent while held in reset.
    assign ifu_req_ready  = rst & grant_ifu;
    assign lsu_req_ready  = rst & grant_lsu;
    assign mem_req_valid  = rst & (state == ISSUE);
    assign mem_resp_ready = rst & ((state == IDLE) | in_err | (in_wait & owner_resp_ready));

    assign ifu_resp_valid = rst & own_ifu & ((in_wait & mem_resp_valid) | in_err);
    assign lsu_resp_valid = rst & own_lsu & ((in_wait & mem_resp_valid) | in_err);
    assign ifu_resp_err   = rst & own_ifu & in_err;
    assign lsu_resp_err   = rst & own_lsu & in_err;
    assign ifu_rdata      = (rst & own_ifu & in_wait) ? fwd_rdata : '0;
    assign lsu_rdata      = (rst & own_lsu & in_wait) ? fwd_rdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_LSU;
            last      <= OWN_LSU;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ifu) begin
                        mem_addr  <= ifu_addr;
                        mem_wen   <= 1'b0;
                        mem_wdata <= '0;
                        mem_wmask <= '0;
                        owner     <= OWN_IFU;
                        last      <= OWN_IFU;
                        state     <= ISSUE;
                    end else if (grant_lsu) begin
                        mem_addr  <= lsu_addr;
                        mem_wen   <= lsu_wen;
                        mem_wdata <= lsu_wdata;
                        mem_wmask <= lsu_wmask;
                        owner     <= OWN_LSU;
                        last      <= OWN_LSU;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid && owner_resp_ready) begin
                        state <= IDLE;
                    end else if (!mem_resp_valid && (TIMEOUT != 0)) begin
                        // A response stalled by the owner is not a hung memory, so only count idle cycles.
                        cnt <= cnt + CNT_ONE;
                        if (cnt + CNT_ONE == CNT_LIMIT)
                            state <= ERR;
                    end
                end
                ERR: begin
                    if (owner_resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised self-checking bench for mem_arbiter with a behavioural memory and
// requester models; expected data and grant order derived from the arbitration rules.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req_valid = 1'b0, ifu_req_ready, ifu_resp_valid, ifu_resp_ready = 1'b0, ifu_resp_err;
    logic [31:0] ifu_addr = '0, ifu_rdata;
    logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_wen = 1'b0, lsu_resp_valid, lsu_resp_ready = 1'b0, lsu_resp_err;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0, lsu_rdata;
    logic [7:0]  lsu_wmask = '0;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int n_checks = 0;
    int n_fail   = 0;

    // memory model controls (written by the main sequence only)
    bit mem_rand_ready = 1'b0;
    bit mem_ready_en   = 1'b1;
    bit mem_mute       = 1'b0;
    int mem_lat_min    = 0;
    int mem_lat_max    = 0;

    // last accepted memory request (written by the memory model only)
    logic [31:0] log_addr = '0, log_wdata = '0;
    logic        log_wen = 1'b0;
    logic [7:0]  log_wmask = '0;

    typedef struct { int who; bit both_valid; bit both_ready; } gnt_t;
    gnt_t gnt_q[$];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WMASK_W(8), .TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0073;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory: drives at the falling edge, observes handshakes 3 time units later.
    initial begin : mem_model
        bit          busy, done;
        int          lat;
        logic [31:0] a;
        logic        w;
        busy = 0; done = 0; lat = 0; a = '0; w = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (done) begin
                busy = 0; done = 0; mem_resp_valid = 1'b0; mem_rdata = '0;
            end
            mem_req_ready = mem_rand_ready ? 1'($urandom_range(0, 1)) : mem_ready_en;
            if (busy && !mem_resp_valid && !mem_mute) begin
                if (lat == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata = w ? $urandom : rd_word(a);
                end else begin
                    lat--;
                end
            end
            #3;
            if (mem_req_valid && mem_req_ready) begin
                busy = 1; a = mem_addr; w = mem_wen;
                lat = $urandom_range(mem_lat_min, mem_lat_max);
                log_addr = mem_addr; log_wen = mem_wen; log_wdata = mem_wdata; log_wmask = mem_wmask;
            end
            if (mem_resp_valid && mem_resp_ready) done = 1;
        end
    end

    // Passive record of every grant (and of each reset) for the ordering checks.
    initial begin : grant_recorder
        bit   in_rst;
        gnt_t g;
        in_rst = 0;
        forever begin
            @(negedge clk); #2;
            if (!rst) begin
                if (!in_rst) begin
                    g.who = 2; g.both_valid = 0; g.both_ready = 0;
                    gnt_q.push_back(g);
                end
                in_rst = 1;
            end else begin
                in_rst = 0;
                if (ifu_req_ready || lsu_req_ready) begin
                    g.who        = ifu_req_ready ? 0 : 1;
                    g.both_valid = ifu_req_valid && lsu_req_valid;
                    g.both_ready = ifu_req_ready && lsu_req_ready;
                    gnt_q.push_back(g);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic ifu_xact(input logic [31:0] a, input int stall, output logic [31:0] got,
                            output logic er, output bit tmo, output bit quiet);
        int n;
        tmo = 0; quiet = 1; got = '0; er = 1'b0;
        @(negedge clk);
        ifu_req_valid = 1'b1; ifu_addr = a; ifu_resp_ready = 1'b0;
        #2; n = 0;
        while (!ifu_req_ready && n < 300) begin @(negedge clk); #2; n++; end
        if (!ifu_req_ready) begin tmo = 1; ifu_req_valid = 1'b0; return; end
        @(negedge clk);
        ifu_req_valid = 1'b0; ifu_addr = $urandom;
        #2; n = 0;
        while (!ifu_resp_valid && n < 300) begin
            if (lsu_resp_valid) quiet = 0;
            @(negedge clk); #2; n++;
        end
        if (!ifu_resp_valid) begin tmo = 1; return; end
        repeat (stall) begin @(negedge clk); #2; end
        if (lsu_resp_valid || !ifu_resp_valid) quiet = 0;
        ifu_resp_ready = 1'b1; got = ifu_rdata; er = ifu_resp_err;
        @(negedge clk);
        ifu_resp_ready = 1'b0;
    endtask

    task automatic lsu_xact(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [7:0] m, input int stall, output logic [31:0] got,
                            output logic er, output bit tmo, output bit quiet);
        int n;
        tmo = 0; quiet = 1; got = '0; er = 1'b0;
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_addr = a; lsu_wen = w; lsu_wdata = d; lsu_wmask = m;
        lsu_resp_ready = 1'b0;
        #2; n = 0;
        while (!lsu_req_ready && n < 300) begin @(negedge clk); #2; n++; end
        if (!lsu_req_ready) begin tmo = 1; lsu_req_valid = 1'b0; return; end
        @(negedge clk);
        lsu_req_valid = 1'b0; lsu_addr = $urandom; lsu_wen = 1'($urandom_range(0, 1));
        lsu_wdata = $urandom; lsu_wmask = 8'($urandom);
        #2; n = 0;
        while (!lsu_resp_valid && n < 300) begin
            if (ifu_resp_valid) quiet = 0;
            @(negedge clk); #2; n++;
        end
        if (!lsu_resp_valid) begin tmo = 1; return; end
        repeat (stall) begin @(negedge clk); #2; end
        if (ifu_resp_valid || !lsu_resp_valid) quiet = 0;
        lsu_resp_ready = 1'b1; got = lsu_rdata; er = lsu_resp_err;
        @(negedge clk);
        lsu_resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        n_checks++;
        if ({ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err, lsu_req_ready, lsu_resp_valid,
             lsu_rdata, lsu_resp_err, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
             mem_resp_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ifu_rdy=%b lsu_rdy=%b mem_v=%b mem_rr=%b addr=%h wen=%b wd=%h wm=%h, required all 0",
                     ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready, mem_addr, mem_wen, mem_wdata, mem_wmask);
        end
        @(negedge clk);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
        rst = 1'b1;
        #2;
        n_checks++;
        if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0 || mem_req_valid !== 1'b0 || mem_resp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_after_reset: ifu_rdy=%b lsu_rdy=%b mem_v=%b mem_rr=%b, required 0 0 0 1",
                     ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready);
        end
    endtask

    task automatic test_round_robin();
        int start, exp_who[4];
        logic [31:0] g0, g1, g2, g3;
        logic e0, e1, e2, e3;
        bit t0, t1, t2, t3, q0, q1, q2, q3;
        exp_who = '{0, 1, 0, 1};
        start = gnt_q.size();
        fork
            begin
                ifu_xact(32'h8000_0100, 0, g0, e0, t0, q0);
                ifu_xact(32'h8000_0104, 1, g1, e1, t1, q1);
            end
            begin
                lsu_xact(32'h9000_0040, 1'b0, '0, '0, 0, g2, e2, t2, q2);
                lsu_xact(32'h9000_0044, 1'b0, '0, '0, 2, g3, e3, t3, q3);
            end
        join
        n_checks++;
        if (gnt_q.size() - start != 4) begin
            n_fail++;
            $display("FAIL rr_grant_count: got %0d grants, required 4", gnt_q.size() - start);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (gnt_q[start+i].who != exp_who[i] || gnt_q[start+i].both_ready) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: grantee %0d (both_ready=%b), required %0d",
                             i, gnt_q[start+i].who, gnt_q[start+i].both_ready, exp_who[i]);
                end
            end
            n_checks++;
            if (!gnt_q[start].both_valid) begin
                n_fail++;
                $display("FAIL rr_contention: first grant saw both_valid=0, required 1");
            end
        end
        n_checks++;
        if ({t0, t1, t2, t3} != 0 || {e0, e1, e2, e3} != 0 || {q0, q1, q2, q3} != 4'hF ||
            g0 !== rd_word(32'h8000_0100) || g1 !== rd_word(32'h8000_0104) ||
            g2 !== rd_word(32'h9000_0040) || g3 !== rd_word(32'h9000_0044)) begin
            n_fail++;
            $display("FAIL rr_data: rdata %h %h %h %h err=%b%b%b%b tmo=%b%b%b%b quiet=%b%b%b%b, required %h %h %h %h err=0 tmo=0 quiet=1",
                     g0, g1, g2, g3, e0, e1, e2, e3, t0, t1, t2, t3, q0, q1, q2, q3,
                     rd_word(32'h8000_0100), rd_word(32'h8000_0104), rd_word(32'h9000_0040), rd_word(32'h9000_0044));
        end
    endtask

    task automatic test_ifu_read();
        logic [31:0] got; logic er; bit tmo, quiet;
        mem_lat_min = 0; mem_lat_max = 0;
        ifu_xact(32'h8000_0000, 0, got, er, tmo, quiet);
        n_checks++;
        if (tmo || got !== 32'h0010_0073 || er !== 1'b0 || !quiet) begin
            n_fail++;
            $display("FAIL ifu_read: rdata=%h err=%b tmo=%b quiet=%b, required 00100073 0 0 1", got, er, tmo, quiet);
        end
        n_checks++;
        if (log_addr !== 32'h8000_0000 || log_wen !== 1'b0 || log_wdata !== '0 || log_wmask !== '0) begin
            n_fail++;
            $display("FAIL ifu_mem_req: addr=%h wen=%b wdata=%h wmask=%h, required 80000000 0 0 0",
                     log_addr, log_wen, log_wdata, log_wmask);
        end
    endtask

    task automatic test_lsu_write();
        logic [31:0] got; logic er; bit tmo, quiet;
        lsu_xact(32'h8000_1000, 1'b1, 32'h1234_5678, 8'h0F, 1, got, er, tmo, quiet);
        n_checks++;
        if (log_addr !== 32'h8000_1000 || log_wen !== 1'b1 || log_wdata !== 32'h1234_5678 || log_wmask !== 8'h0F) begin
            n_fail++;
            $display("FAIL lsu_write_req: addr=%h wen=%b wdata=%h wmask=%h, required 80001000 1 12345678 0f",
                     log_addr, log_wen, log_wdata, log_wmask);
        end
        n_checks++;
        if (tmo || got !== '0 || er !== 1'b0 || !quiet) begin
            n_fail++;
            $display("FAIL lsu_write_resp: rdata=%h err=%b tmo=%b quiet=%b, required 0 0 0 1", got, er, tmo, quiet);
        end
    endtask

    task automatic test_issue_stall();
        logic [31:0] got; logic er; bit tmo, quiet, stable, seen;
        mem_ready_en = 1'b0;
        stable = 1; seen = 0;
        fork
            ifu_xact(32'h8000_2468, 0, got, er, tmo, quiet);
            begin
                for (int n = 0; n < 50 && !seen; n++) begin
                    @(negedge clk); #2;
                    seen = mem_req_valid;
                end
                for (int i = 0; i < 10; i++) begin
                    if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_2468 || mem_wen !== 1'b0 ||
                        ifu_resp_valid !== 1'b0 || ifu_resp_err !== 1'b0) stable = 0;
                    @(negedge clk); #2;
                end
                mem_ready_en = 1'b1;
            end
        join
        n_checks++;
        if (!seen || !stable) begin
            n_fail++;
            $display("FAIL issue_stall: mem_req_valid seen=%b stable=%b, required 1 1", seen, stable);
        end
        n_checks++;
        if (tmo || got !== rd_word(32'h8000_2468) || er !== 1'b0) begin
            n_fail++;
            $display("FAIL issue_stall_resp: rdata=%h err=%b tmo=%b, required %h 0 0",
                     got, er, tmo, rd_word(32'h8000_2468));
        end
    endtask

    task automatic test_timeout();
        int n;
        bit ok;
        logic [31:0] got; logic er; bit tmo, quiet;
        mem_mute = 1'b1; mem_ready_en = 1'b1; mem_lat_min = 0; mem_lat_max = 0;
        @(negedge clk);
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_3000; ifu_resp_ready = 1'b0;
        #2; n = 0;
        while (!ifu_req_ready && n < 50) begin @(negedge clk); #2; n++; end
        @(negedge clk);
        ifu_req_valid = 1'b0;
        #2; n = 0;
        while (!ifu_resp_valid && n < 50) begin @(negedge clk); #2; n++; end
        // accept edge, then TO idle WAIT cycles, then the error appears one sample later
        n_checks++;
        if (n != TO + 1) begin
            n_fail++;
            $display("FAIL timeout_cycles: error response after %0d cycles, required %0d", n, TO + 1);
        end
        n_checks++;
        if (ifu_resp_valid !== 1'b1 || ifu_resp_err !== 1'b1 || ifu_rdata !== '0 || lsu_resp_valid !== 1'b0 || mem_resp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_resp: valid=%b err=%b rdata=%h lsu_valid=%b mem_rr=%b, required 1 1 0 0 1",
                     ifu_resp_valid, ifu_resp_err, ifu_rdata, lsu_resp_valid, mem_resp_ready);
        end
        ifu_resp_ready = 1'b1;
        @(negedge clk);
        ifu_resp_ready = 1'b0;
        #2;
        mem_mute = 1'b0;
        ok = 0; n = 0;
        while (!mem_resp_valid && n < 20) begin @(negedge clk); #2; n++; end
        n_checks++;
        if (!mem_resp_valid || ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 || mem_resp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL late_resp_drop: mem_rv=%b ifu_valid=%b lsu_valid=%b mem_rr=%b, required 1 0 0 1",
                     mem_resp_valid, ifu_resp_valid, lsu_resp_valid, mem_resp_ready);
        end
        repeat (2) @(negedge clk);
        ifu_xact(32'h8000_3004, 0, got, er, tmo, quiet);
        n_checks++;
        if (tmo || got !== rd_word(32'h8000_3004) || er !== 1'b0 || !quiet) begin
            n_fail++;
            $display("FAIL after_timeout: rdata=%h err=%b tmo=%b, required %h 0 0", got, er, tmo, rd_word(32'h8000_3004));
        end
    endtask

    task automatic test_reset_in_wait();
        int n;
        logic [31:0] got; logic er; bit tmo, quiet;
        mem_lat_min = 12; mem_lat_max = 12;
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_addr = 32'h9000_5000; lsu_wen = 1'b0; lsu_resp_ready = 1'b0;
        #2; n = 0;
        while (!lsu_req_ready && n < 50) begin @(negedge clk); #2; n++; end
        @(negedge clk);
        lsu_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err, lsu_req_ready, lsu_resp_valid,
             lsu_rdata, lsu_resp_err, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
             mem_resp_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_in_wait: lsu_v=%b mem_v=%b mem_rr=%b addr=%h, required all 0",
                     lsu_resp_valid, mem_req_valid, mem_resp_ready, mem_addr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #2; n = 0;
        while (!mem_resp_valid && n < 40) begin @(negedge clk); #2; n++; end
        n_checks++;
        if (!mem_resp_valid || lsu_resp_valid !== 1'b0 || ifu_resp_valid !== 1'b0 || mem_resp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stale_drain: mem_rv=%b lsu_valid=%b ifu_valid=%b mem_rr=%b, required 1 0 0 1",
                     mem_resp_valid, lsu_resp_valid, ifu_resp_valid, mem_resp_ready);
        end
        repeat (2) @(negedge clk);
        mem_lat_min = 0; mem_lat_max = 0;
        lsu_xact(32'h9000_5004, 1'b0, '0, '0, 0, got, er, tmo, quiet);
        n_checks++;
        if (tmo || got !== rd_word(32'h9000_5004) || er !== 1'b0 || !quiet) begin
            n_fail++;
            $display("FAIL after_reset: rdata=%h err=%b tmo=%b, required %h 0 0", got, er, tmo, rd_word(32'h9000_5004));
        end
    endtask

    task automatic test_random();
        int start, prev;
        mem_rand_ready = 1'b1; mem_lat_min = 0; mem_lat_max = 3;
        start = gnt_q.size();
        fork
            for (int i = 0; i < 25; i++) begin
                logic [31:0] a, got; logic er; bit tmo, quiet;
                a = $urandom & 32'hEFFF_FFFC;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                ifu_xact(a, $urandom_range(0, 3), got, er, tmo, quiet);
                n_checks++;
                if (tmo || got !== rd_word(a) || er !== 1'b0 || !quiet) begin
                    n_fail++;
                    $display("FAIL rand_ifu[%0d]: addr=%h rdata=%h err=%b tmo=%b quiet=%b, required %h 0 0 1",
                             i, a, got, er, tmo, quiet, rd_word(a));
                end
            end
            for (int i = 0; i < 25; i++) begin
                logic [31:0] a, d, got, exp; logic w, er; bit tmo, quiet;
                a = $urandom | 32'h1000_0000;
                w = 1'($urandom_range(0, 1));
                d = $urandom;
                exp = w ? 32'h0 : rd_word(a);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                lsu_xact(a, w, d, 8'($urandom), $urandom_range(0, 3), got, er, tmo, quiet);
                n_checks++;
                if (tmo || got !== exp || er !== 1'b0 || !quiet) begin
                    n_fail++;
                    $display("FAIL rand_lsu[%0d]: addr=%h wen=%b rdata=%h err=%b tmo=%b quiet=%b, required %h 0 0 1",
                             i, a, w, got, er, tmo, quiet, exp);
                end
            end
        join
        mem_rand_ready = 1'b0; mem_lat_max = 0;
        prev = 1;
        for (int i = 0; i < start; i++) prev = (gnt_q[i].who == 2) ? 1 : gnt_q[i].who;
        for (int i = start; i < gnt_q.size(); i++) begin
            if (gnt_q[i].who == 2) begin
                prev = 1;
                continue;
            end
            n_checks++;
            if (gnt_q[i].both_ready || (gnt_q[i].both_valid && gnt_q[i].who == prev)) begin
                n_fail++;
                $display("FAIL rand_rr[%0d]: grantee %0d both_valid=%b both_ready=%b previous %0d, required other than previous on contention, single ready",
                         i, gnt_q[i].who, gnt_q[i].both_valid, gnt_q[i].both_ready, prev);
            end
            prev = gnt_q[i].who;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_ifu_read();
        test_lsu_write();
        test_issue_stall();
        test_timeout();
        test_random();
        test_reset_in_wait();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
